// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file write-port arbiter with extension and pending-write scoreboard
module reg_wb_arbiter #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int XLEN           = 64,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0]    alu_waddr,
    input  logic [XLEN-1:0]              alu_wdata,
    input  logic [1:0]                   alu_ext,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [REG_ADDR_WIDTH-1:0]    lsu_waddr,
    input  logic [XLEN-1:0]              lsu_wdata,
    input  logic [1:0]                   lsu_ext,
    input  logic                         issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]    issue_rd,
    input  logic                         flush,
    output logic                         reg_wen,
    output logic [REG_ADDR_WIDTH-1:0]    reg_waddr,
    output logic [XLEN-1:0]              reg_wdata,
    output logic [2**REG_ADDR_WIDTH-1:0] busy_vec
);

    localparam int NREG = 2**REG_ADDR_WIDTH;
    localparam int CW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]             starve_cnt;
    logic [CW-1:0]             starve_cnt_next;
    logic                      alu_xfer;
    logic                      lsu_xfer;
    logic                      xfer;
    logic                      write_next;
    logic [REG_ADDR_WIDTH-1:0] xfer_waddr;
    logic [XLEN-1:0]           xfer_wdata;
    logic [NREG-1:0]           busy_next;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] mode);
        case (mode)
            2'd1:    return {{(XLEN-32){d[31]}}, d[31:0]};
            2'd2:    return {{(XLEN-32){1'b0}}, d[31:0]};
            default: return d;
        endcase
    endfunction

    // LSU has priority until the ALU has lost STARVE_LIMIT consecutive cycles.
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst && !flush) begin
            if (alu_valid && (!lsu_valid || starve_cnt == LIMIT)) begin
                alu_ready = 1'b1;
            end else if (lsu_valid) begin
                lsu_ready = 1'b1;
            end
        end
    end

    always_comb begin
        alu_xfer   = alu_valid && alu_ready;
        lsu_xfer   = lsu_valid && lsu_ready;
        xfer       = alu_xfer || lsu_xfer;
        xfer_waddr = alu_xfer ? alu_waddr : lsu_waddr;
        xfer_wdata = alu_xfer ? extend(alu_wdata, alu_ext) : extend(lsu_wdata, lsu_ext);
        write_next = xfer && (xfer_waddr != '0);
    end

    always_comb begin
        starve_cnt_next = starve_cnt;
        if (flush || !alu_valid || alu_xfer) begin
            starve_cnt_next = '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt_next = starve_cnt + CW'(1);
        end
    end

    // Clear for the retiring write first, then set for the new issue so set wins.
    always_comb begin
        busy_next = busy_vec;
        if (flush) begin
            busy_next = '0;
        end else if (xfer) begin
            busy_next[xfer_waddr] = 1'b0;
        end
        if (issue_valid && issue_rd != '0) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wen    <= 1'b0;
            reg_waddr  <= '0;
            reg_wdata  <= '0;
            busy_vec   <= '0;
            starve_cnt <= '0;
        end else begin
            reg_wen    <= write_next;
            busy_vec   <= busy_next;
            starve_cnt <= starve_cnt_next;
            if (write_next) begin
                reg_waddr <= xfer_waddr;
                reg_wdata <= xfer_wdata;
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    localparam int AW  = 5;
    localparam int XL  = 64;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready;
    logic [AW-1:0] alu_waddr;
    logic [XL-1:0] alu_wdata;
    logic [1:0]    alu_ext;
    logic          lsu_valid, lsu_ready;
    logic [AW-1:0] lsu_waddr;
    logic [XL-1:0] lsu_wdata;
    logic [1:0]    lsu_ext;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          flush;
    logic          reg_wen;
    logic [AW-1:0] reg_waddr;
    logic [XL-1:0] reg_wdata;
    logic [31:0]   busy_vec;

    int n_cmp = 0;
    int n_bad = 0;

    reg_wb_arbiter #(.REG_ADDR_WIDTH(AW), .XLEN(XL), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr),
        .alu_wdata(alu_wdata), .alu_ext(alu_ext),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr),
        .lsu_wdata(lsu_wdata), .lsu_ext(lsu_ext),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [XL-1:0] ad;
        logic [1:0]    ae;
        logic          lv;
        logic [AW-1:0] la;
        logic [XL-1:0] ld;
        logic [1:0]    le;
        logic          fl;
        logic          e_ar;
        logic          e_lr;
        logic          e_wen;
        logic [AW-1:0] e_wa;
        logic [XL-1:0] e_wd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_waddr = '0; alu_wdata = '0; alu_ext = '0;
        lsu_valid = 0; lsu_waddr = '0; lsu_wdata = '0; lsu_ext = '0;
        issue_valid = 0; issue_rd = '0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    function automatic logic [63:0] ext_ref(input logic [63:0] d, input logic [1:0] e);
        logic [31:0] lo;
        lo = d[31:0];
        if (e == 2'd1) return 64'($signed(lo));
        if (e == 2'd2) return 64'(lo);
        return d;
    endfunction

    // reference model state
    int          m_streak;
    logic [31:0] m_busy;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;

    initial begin
        logic g_alu, g_lsu, xfer;
        logic [4:0]  wa;
        logic [63:0] wd;

        tbl[0] = '{1'b1, 5'd5, 64'h1234, 2'd0, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0,
                   1'b1, 1'b0, 1'b1, 5'd5, 64'h1234};
        tbl[1] = '{1'b0, 5'd0, 64'd0, 2'd0, 1'b1, 5'd3, 64'h0000_0000_8000_0001, 2'd1, 1'b0,
                   1'b0, 1'b1, 1'b1, 5'd3, 64'hFFFF_FFFF_8000_0001};
        tbl[2] = '{1'b0, 5'd0, 64'd0, 2'd0, 1'b1, 5'd3, 64'h0000_0000_8000_0001, 2'd2, 1'b0,
                   1'b0, 1'b1, 1'b1, 5'd3, 64'h0000_0000_8000_0001};
        tbl[3] = '{1'b1, 5'd9, 64'hFFFF_0000_8000_0000, 2'd3, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0,
                   1'b1, 1'b0, 1'b1, 5'd9, 64'hFFFF_0000_8000_0000};
        tbl[4] = '{1'b1, 5'd2, 64'h1234_5678_7FFF_FFFF, 2'd1, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0,
                   1'b1, 1'b0, 1'b1, 5'd2, 64'h0000_0000_7FFF_FFFF};
        tbl[5] = '{1'b0, 5'd0, 64'd0, 2'd0, 1'b1, 5'd6, 64'hDEAD_BEEF_FFFF_FFFF, 2'd2, 1'b0,
                   1'b0, 1'b1, 1'b1, 5'd6, 64'h0000_0000_FFFF_FFFF};
        tbl[6] = '{1'b1, 5'd0, 64'h77, 2'd0, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0,
                   1'b1, 1'b0, 1'b0, 5'd0, 64'd0};
        tbl[7] = '{1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'd0, 64'd0, 2'd0, 1'b0,
                   1'b0, 1'b0, 1'b0, 5'd0, 64'd0};
        tbl[8] = '{1'b1, 5'd4, 64'h1, 2'd0, 1'b1, 5'd8, 64'h2, 2'd0, 1'b1,
                   1'b0, 1'b0, 1'b0, 5'd0, 64'd0};
        tbl[9] = '{1'b1, 5'd4, 64'h1, 2'd0, 1'b1, 5'd8, 64'hABCD_0000_1234_5678, 2'd1, 1'b0,
                   1'b0, 1'b1, 1'b1, 5'd8, 64'h0000_0000_1234_5678};

        // reset: readies held low while rst is high
        idle();
        rst = 1;
        alu_valid = 1;
        lsu_valid = 1;
        #1;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        tick();
        tick();
        chk("rst_wen", reg_wen, 0);
        chk("rst_waddr", reg_waddr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_busy", busy_vec, 0);
        rst = 0;
        idle();
        tick();

        for (int i = 0; i < 10; i++) begin
            alu_valid = tbl[i].av; alu_waddr = tbl[i].aa; alu_wdata = tbl[i].ad; alu_ext = tbl[i].ae;
            lsu_valid = tbl[i].lv; lsu_waddr = tbl[i].la; lsu_wdata = tbl[i].ld; lsu_ext = tbl[i].le;
            flush = tbl[i].fl;
            #1;
            chk($sformatf("vec%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
            chk($sformatf("vec%0d_lsu_ready", i), lsu_ready, tbl[i].e_lr);
            tick();
            chk($sformatf("vec%0d_wen", i), reg_wen, tbl[i].e_wen);
            if (tbl[i].e_wen) begin
                chk($sformatf("vec%0d_waddr", i), reg_waddr, tbl[i].e_wa);
                chk($sformatf("vec%0d_wdata", i), reg_wdata, tbl[i].e_wd);
            end
            idle();
            tick();
            if (tbl[i].e_wen) begin
                chk($sformatf("vec%0d_hold_wen", i), reg_wen, 0);
                chk($sformatf("vec%0d_hold_waddr", i), reg_waddr, tbl[i].e_wa);
                chk($sformatf("vec%0d_hold_wdata", i), reg_wdata, tbl[i].e_wd);
            end
        end

        // contention: LSU wins LIM times, then ALU once, then LSU again
        do_reset();
        alu_valid = 1; alu_waddr = 5'd10; alu_wdata = 64'hAA;
        lsu_valid = 1; lsu_waddr = 5'd11; lsu_wdata = 64'hBB;
        for (int c = 0; c <= LIM + 1; c++) begin
            #1;
            chk($sformatf("starve%0d_alu_ready", c), alu_ready, c == LIM);
            chk($sformatf("starve%0d_lsu_ready", c), lsu_ready, c != LIM);
            tick();
            chk($sformatf("starve%0d_waddr", c), reg_waddr, (c == LIM) ? 5'd10 : 5'd11);
        end
        idle();

        // scoreboard: set on issue, set wins over same-cycle clear, later clear
        do_reset();
        issue_valid = 1; issue_rd = 5'd7;
        tick();
        idle();
        chk("sb_issue7", busy_vec, 32'h80);
        alu_valid = 1; alu_waddr = 5'd7; alu_wdata = 64'h5;
        issue_valid = 1; issue_rd = 5'd7;
        tick();
        idle();
        chk("sb_set_wins", busy_vec, 32'h80);
        chk("sb_set_wins_wen", reg_wen, 1);
        alu_valid = 1; alu_waddr = 5'd7; alu_wdata = 64'h6;
        tick();
        idle();
        chk("sb_clear7", busy_vec, 32'h0);
        issue_valid = 1; issue_rd = 5'd0;
        tick();
        chk("sb_issue_x0", busy_vec, 32'h0);
        issue_rd = 5'd3;
        tick();
        idle();
        alu_valid = 1; alu_waddr = 5'd0; alu_wdata = 64'h9;
        #1;
        chk("x0_alu_ready", alu_ready, 1);
        tick();
        idle();
        chk("x0_wen", reg_wen, 0);
        chk("x0_busy", busy_vec, 32'h8);

        // flush with both valid, same-cycle issue still lands
        alu_valid = 1; alu_waddr = 5'd3; lsu_valid = 1; lsu_waddr = 5'd4;
        flush = 1; issue_valid = 1; issue_rd = 5'd9;
        #1;
        chk("flush_alu_ready", alu_ready, 0);
        chk("flush_lsu_ready", lsu_ready, 0);
        tick();
        idle();
        chk("flush_busy", busy_vec, 32'h200);
        chk("flush_wen", reg_wen, 0);

        // reset while a write is on the port
        alu_valid = 1; alu_waddr = 5'd12; alu_wdata = 64'h55;
        tick();
        idle();
        chk("pre_rst_wen", reg_wen, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_wen", reg_wen, 0);
        chk("mid_rst_waddr", reg_waddr, 0);
        chk("mid_rst_wdata", reg_wdata, 0);
        chk("mid_rst_busy", busy_vec, 0);

        // randomized traffic against the reference model
        do_reset();
        m_streak = 0; m_busy = '0; m_wen = 0; m_waddr = '0; m_wdata = '0;
        for (int n = 0; n < 400; n++) begin
            g_alu = !flush && alu_valid && (!lsu_valid || m_streak >= LIM);
            g_lsu = !flush && lsu_valid && !g_alu;
            #1;
            chk("rnd_alu_ready", alu_ready, g_alu);
            chk("rnd_lsu_ready", lsu_ready, g_lsu);
            xfer = g_alu || g_lsu;
            wa = g_alu ? alu_waddr : lsu_waddr;
            wd = g_alu ? ext_ref(alu_wdata, alu_ext) : ext_ref(lsu_wdata, lsu_ext);
            m_wen = xfer && wa != 0;
            if (m_wen) begin
                m_waddr = wa;
                m_wdata = wd;
            end
            if (flush || !alu_valid || g_alu) m_streak = 0;
            else if (m_streak < LIM) m_streak++;
            if (flush) m_busy = '0;
            else if (xfer) m_busy[wa] = 1'b0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            tick();
            chk("rnd_wen", reg_wen, m_wen);
            if (m_wen) begin
                chk("rnd_waddr", reg_waddr, m_waddr);
                chk("rnd_wdata", reg_wdata, m_wdata);
            end
            chk("rnd_busy", busy_vec, m_busy);
            if (!alu_valid || g_alu) begin
                alu_valid = $urandom_range(0, 2) != 0;
                alu_waddr = AW'($urandom_range(0, 31));
                alu_wdata = {$urandom(), $urandom()};
                alu_ext   = 2'($urandom_range(0, 3));
            end
            if (!lsu_valid || g_lsu) begin
                lsu_valid = $urandom_range(0, 2) != 0;
                lsu_waddr = AW'($urandom_range(0, 31));
                lsu_wdata = {$urandom(), $urandom()};
                lsu_ext   = 2'($urandom_range(0, 3));
            end
            issue_valid = $urandom_range(0, 1) != 0;
            issue_rd    = AW'($urandom_range(0, 31));
            flush       = $urandom_range(0, 15) == 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
